rd_ptr_ctrl: RTL and testbench
==============================

Name: rd_ptr_ctrl

Overview:
Read-domain pointer and flag controller for the parametrised async FIFO. It is the successor to the fixed 4-bit read pointer block.
- Generalised to any depth 2^ADDR_W.
- Adds registered fill level, programmable almost-empty flag, sticky underflow detection and an optional built-in write-pointer synchroniser.
- Sits between the FIFO RAM read port and the write-to-read pointer crossing.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH; legal range 0..2^ADDR_W.
SYNC_STAGES, 2, synchroniser depth (used only with RPTR_SYNC_EN); minimum 2.

Ports:
r_clk  in  1  read-domain clock; all state updates on rising edge.
rrst  in  1  synchronous active-high reset.
r_en  in  1  read request.
g_wptr_sync  in  ADDR_W+1  Gray write pointer (already synchronised, or raw when RPTR_SYNC_EN is defined).
uf_clr  in  1  clears sticky underflow.
g_rptr  out  ADDR_W+1  registered Gray read pointer, to the write domain.
b_rptr  out  ADDR_W+1  registered binary read pointer.
r_addr  out  ADDR_W  RAM read address = b_rptr[ADDR_W-1:0].
empty  out  1  registered empty flag.
almost_empty  out  1  registered almost-empty flag.
r_level  out  ADDR_W+1  registered occupancy, 0..2^ADDR_W.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- One clock (r_clk). Reset is synchronous, active-high (rrst), sampled on the rising edge of r_clk; no asynchronous reset path.
- Reset values: g_rptr=0, b_rptr=0, empty=1, almost_empty=1, r_level=0, underflow=0. rrst overrides all other inputs in the same edge, including r_en.
- Read acceptance: rd_ok = r_en & ~empty. Reads while empty never move pointers.
- Pointer update:
  - b_next = b_rptr + rd_ok, modulo 2^(ADDR_W+1).
  - g_next = b_next ^ (b_next >> 1).
  - Both are registered every cycle.
- Write pointer conversion: wbin = Gray-to-binary of the synchronised write pointer (XOR prefix from MSB down).
- Flag and level updates, all registered and all computed from the next-state pointer, so zero extra latency after an accepted read:
  - empty <= (g_next == synchronised write pointer).
  - r_level <= (wbin - b_next) modulo 2^(ADDR_W+1).
  - almost_empty <= (level_next <= AE_THRESH).
- Wrap-around: pointer MSB toggles on each pass through depth; level subtraction is modular, so level is correct across wrap. Level 2^ADDR_W is a full FIFO, with MSBs differing and the rest equal.
- Underflow:
  - underflow <= 1 when r_en & empty.
  - uf_clr clears it.
  - A simultaneous new underflow and uf_clr leaves underflow = 1 (set wins).
- Pessimism: the synchronised write pointer lags the true write pointer. empty and r_level may therefore be conservative (report emptier than actual) but never optimistic.
- Input requirement: g_wptr_sync changes at most one bit per r_clk after synchronisation (Gray property); not checked.

Optional Feature:
RPTR_SYNC_EN
- Defined:
  - g_wptr_sync is treated as raw write-domain Gray and passed through a SYNC_STAGES-deep flop chain in r_clk.
  - The chain resets to 0 on rrst.
  - Flags and level see write-pointer changes SYNC_STAGES cycles later.
- Undefined: the input is used directly; SYNC_STAGES is ignored.

Test Plan:
(ADDR_W=3, AE_THRESH=1, RPTR_SYNC_EN undefined)
1. Reset: rrst=1 for 2 cycles, r_en=1 -> g_rptr=0000, b_rptr=0000, empty=1, almost_empty=1, r_level=0, underflow=0; r_en ignored.
2. Drain: g_wptr_sync=0010 (bin 3), r_en=0 for 1 cycle -> empty=0, r_level=3, almost_empty=0. Then r_en=1 for 3 cycles:
   - b_rptr = 1, 2, 3.
   - g_rptr = 0001, 0011, 0010.
   - r_level = 2, 1, 0.
   - almost_empty=1 from level 1.
   - empty=1 after third read.
3. Underflow: empty=1, r_en=1 for 1 cycle -> b_rptr unchanged, underflow=1 next edge, held. Then uf_clr=1 with r_en=0 -> underflow=0. Then uf_clr=1 with r_en=1 while empty -> underflow stays 1.
4. Wrap: read to b_rptr=14 (g_rptr=1001), then g_wptr_sync=0000 (bin 16 mod 16) -> r_level=2, empty=0. Two reads -> b_rptr=15 then 0, g_rptr=1000 then 0000, empty=1, r_level=0.
5. Full: b_rptr=0, g_wptr_sync=1100 (bin 8) -> r_level=8, empty=0, almost_empty=0.
6. Reset mid-stream: b_rptr=5, r_en=1, rrst=1 for 1 cycle -> next edge all reset values. With RPTR_SYNC_EN defined, the flag response to a write-pointer change is delayed exactly 2 extra cycles.

Source files
------------

// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: read-domain pointer and flag controller for the async FIFO.
// Keeps the binary and Gray read pointers. Derives empty, almost_empty and the
// fill level from the next-state pointer, so a read is reflected on the same
// edge that accepts it. Holds a sticky underflow flag.
// Build option: define RPTR_SYNC_EN to add an internal SYNC_STAGES-deep
// synchroniser on g_wptr_sync. Without it, the input is used as already synchronised.
module rd_ptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int AE_THRESH   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              r_clk,
  input  logic              rrst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   g_wptr_sync,
  input  logic              uf_clr,
  output logic [ADDR_W:0]   g_rptr,
  output logic [ADDR_W:0]   b_rptr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   r_level,
  output logic              underflow
);

  localparam logic [ADDR_W+1:0] AE_T = (ADDR_W+2)'(AE_THRESH);

  logic [ADDR_W:0] b_rptr_q, b_rptr_d;
  logic [ADDR_W:0] g_rptr_q, g_rptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            empty_q, empty_d;
  logic            ae_q, ae_d;
  logic            uf_q, uf_d;
  logic [ADDR_W:0] gw;
  logic [ADDR_W:0] wbin;
  logic            rd_ok;

`ifdef RPTR_SYNC_EN
  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;

  // Write-pointer synchroniser chain. It resets to zero so that empty re-evaluates cleanly.
  always_ff @(posedge r_clk) begin
    if (rrst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], g_wptr_sync};
  end

  assign gw = sync_q[SYNC_STAGES-1];
`else
  assign gw = g_wptr_sync;
`endif

  // Gray-to-binary conversion of the write pointer: XOR prefix from the MSB down.
  always_comb begin
    wbin         = '0;
    wbin[ADDR_W] = gw[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--)
      wbin[i] = wbin[i+1] ^ gw[i];
  end

  // Next-state pointers and flags. All are derived from the post-read pointer.
  always_comb begin
    rd_ok    = r_en & ~empty_q;
    b_rptr_d = b_rptr_q + {{ADDR_W{1'b0}}, rd_ok};
    g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);
    empty_d  = (g_rptr_d == gw);
    level_d  = wbin - b_rptr_d;
    ae_d     = ({1'b0, level_d} <= AE_T);
    // The set condition is applied after the clear, so a new underflow wins over uf_clr.
    uf_d     = uf_q;
    if (uf_clr)         uf_d = 1'b0;
    if (r_en & empty_q) uf_d = 1'b1;
  end

  // State registers. A synchronous reset overrides every other input.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      b_rptr_q <= '0;
      g_rptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      uf_q     <= 1'b0;
    end else begin
      b_rptr_q <= b_rptr_d;
      g_rptr_q <= g_rptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      uf_q     <= uf_d;
    end
  end

  assign g_rptr       = g_rptr_q;
  assign b_rptr       = b_rptr_q;
  assign r_addr       = b_rptr_q[ADDR_W-1:0];
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign r_level      = level_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// tb_rd_ptr_ctrl: directed test of rd_ptr_ctrl with ADDR_W=3 and AE_THRESH=1.
module tb_rd_ptr_ctrl;

  localparam int AW = 3;
`ifdef RPTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          r_clk = 1'b0;
  logic          rrst, r_en, uf_clr;
  logic [AW:0]   g_wptr_sync;
  logic [AW:0]   g_rptr, b_rptr, r_level;
  logic [AW-1:0] r_addr;
  logic          empty, almost_empty, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  rd_ptr_ctrl #(.ADDR_W(AW), .AE_THRESH(1), .SYNC_STAGES(2)) dut (
    .r_clk        (r_clk),
    .rrst         (rrst),
    .r_en         (r_en),
    .g_wptr_sync  (g_wptr_sync),
    .uf_clr       (uf_clr),
    .g_rptr       (g_rptr),
    .b_rptr       (b_rptr),
    .r_addr       (r_addr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .r_level      (r_level),
    .underflow    (underflow)
  );

  always #5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [AW:0] eb, input logic [AW:0] eg,
                         input logic [AW:0] el, input logic ee, input logic eae, input logic euf);
    chk({tag, ".b_rptr"}, 32'(b_rptr), 32'(eb));
    chk({tag, ".g_rptr"}, 32'(g_rptr), 32'(eg));
    chk({tag, ".r_addr"}, 32'(r_addr), 32'(eb[AW-1:0]));
    chk({tag, ".level"},  32'(r_level), 32'(el));
    chk({tag, ".empty"},  32'(empty), 32'(ee));
    chk({tag, ".ae"},     32'(almost_empty), 32'(eae));
    chk({tag, ".uf"},     32'(underflow), 32'(euf));
  endtask

  // Drain table: b_rptr, g_rptr, level, empty, almost_empty after each read.
  logic [AW:0] dr_b [3] = '{4'd1, 4'd2, 4'd3};
  logic [AW:0] dr_g [3] = '{4'b0001, 4'b0011, 4'b0010};
  logic [AW:0] dr_l [3] = '{4'd2, 4'd1, 4'd0};
  logic        dr_e [3] = '{1'b0, 1'b0, 1'b1};
  logic        dr_a [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    rrst = 1'b1; r_en = 1'b1; uf_clr = 1'b0; g_wptr_sync = '0;
    @(negedge r_clk);
    // Reset, with r_en held high.
    tick(2);
    chk_all("reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);

    // Drain three entries.
    rrst = 1'b0; r_en = 1'b0; g_wptr_sync = 4'b0010;
    tick(1 + LAT);
    chk_all("fill3", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("drain%0d", i), dr_b[i], dr_g[i], dr_l[i], dr_e[i], dr_a[i], 1'b0);
    end

    // Underflow: a read while empty, then hold, then clear, then set-wins.
    tick();
    chk_all("uf_set", 4'd3, 4'b0010, 4'd0, 1'b1, 1'b1, 1'b1);
    r_en = 1'b0;
    tick();
    chk("uf_hold", 32'(underflow), 32'd1);
    uf_clr = 1'b1;
    tick();
    chk("uf_clr", 32'(underflow), 32'd0);
    r_en = 1'b1;
    tick();
    chk("uf_setwins", 32'(underflow), 32'd1);
    chk("uf_noptr", 32'(b_rptr), 32'd3);
    uf_clr = 1'b0; r_en = 1'b0;

    // Wrap: advance to b_rptr=14, then a write pointer of 16 (Gray 0000).
    g_wptr_sync = 4'b1001;
    tick(1 + LAT);
    chk("lvl11", 32'(r_level), 32'd11);
    r_en = 1'b1;
    tick(11);
    chk_all("at14", 4'd14, 4'b1001, 4'd0, 1'b1, 1'b1, 1'b1);
    r_en = 1'b0; g_wptr_sync = 4'b0000;
    tick(1 + LAT);
    chk_all("wrap_l2", 4'd14, 4'b1001, 4'd2, 1'b0, 1'b0, 1'b1);
    r_en = 1'b1;
    tick();
    chk_all("wrap15", 4'd15, 4'b1000, 4'd1, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("wrap0", 4'd0, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b1);
    r_en = 1'b0;

    // Full: a write pointer of 8 against a read pointer of 0.
    g_wptr_sync = 4'b1100;
    tick(1 + LAT);
    chk_all("full", 4'd0, 4'b0000, 4'd8, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a read stream.
    r_en = 1'b1;
    tick(5);
    chk_all("mid5", 4'd5, 4'b0111, 4'd3, 1'b0, 1'b0, 1'b1);
    rrst = 1'b1;
    tick();
    chk_all("midrst", 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    rrst = 1'b0; r_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
